conv2_window_loader: RTL and testbench

- Buffers one complete binary layer-1 feature map of FM_DIM x FM_DIM x CHAN bits.
- The map arrives as a raster stream, one CHAN-bit channel vector per beat.
- The block then emits the WIN x WIN x CHAN windows, at stride STRIDE, that feed the layer-2 conv/pool channel array (flat image vector of CHAN*6*6 bits).
- Sits between the layer-1 conv/pool stage and the layer-2 conv/pool channel array. Frame-at-a-time, no double buffering.

---
 rtl/cnn_pkg.sv | 16 +
 rtl/window_slice.sv | 33 +++
 rtl/conv2_window_loader.sv | 138 +++++++++++++
 tb/tb_conv2_window_loader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Purpose: shared geometry constants and FSM state type for the layer-2 window loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cnn_pkg;
    localparam int CHAN1   = 18;
    localparam int FM1_DIM = 12;
    localparam int WIN     = 6;
    localparam int STRIDE  = 2;
    localparam int OUT_DIM = (FM1_DIM - WIN) / STRIDE + 1;

    typedef enum logic [1:0] {
        LOAD,
        EMIT,
        DONE
    } fsm_t;
endpackage

// File: rtl/window_slice.sv
// Purpose: combinational mux cutting one WIN x WIN x CHAN window out of the frame buffer.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows row_i/col_i and buffer contents.
// Ports: mem_i = frame buffer, one CHAN-bit entry per (row*FM_DIM + col);
//        row_i/col_i = window position; image_o = flat window, index c*WIN*WIN + r*WIN + k.
module window_slice #(
    parameter int CHAN   = cnn_pkg::CHAN1,
    parameter int FM_DIM = cnn_pkg::FM1_DIM,
    parameter int WIN    = cnn_pkg::WIN,
    parameter int STRIDE = cnn_pkg::STRIDE,
    parameter int OW     = 2
) (
    input  logic [CHAN-1:0] mem_i [FM_DIM*FM_DIM],
    input  logic [OW-1:0]   row_i,
    input  logic [OW-1:0]   col_i,
    output logic            image_o [0:CHAN*WIN*WIN-1]
);
    localparam int AW = $clog2(FM_DIM*FM_DIM);

    import cnn_pkg::*;

    for (genvar r = 0; r < WIN; r++) begin : g_row
        for (genvar k = 0; k < WIN; k++) begin : g_col
            // Buffer entry feeding tap (r,k); the largest index reachable is
            // FM_DIM-1 on both axes, so the truncating cast never drops bits.
            logic [AW-1:0] addr;
            assign addr = AW'((int'(row_i) * STRIDE + r) * FM_DIM + int'(col_i) * STRIDE + k);
            for (genvar c = 0; c < CHAN; c++) begin : g_ch
                assign image_o[c*WIN*WIN + r*WIN + k] = mem_i[addr][c];
            end
        end
    end
endmodule

// File: rtl/conv2_window_loader.sv
// Purpose: buffers one binary FM_DIM x FM_DIM x CHAN feature map, then emits strided WIN x WIN windows.
// Latency: first window the cycle after the last input beat; one window per cycle; 1-cycle DONE.
// Backpressure: in_ready low outside LOAD; windows hold steady while win_ready is low.
// Ports: clk/rst (async active-high); in_valid/in_ready/in_pix raster input stream;
//        win_valid/win_ready/win_image/win_row/win_col window output; frame_done end-of-frame pulse.
module conv2_window_loader #(
    parameter int CHAN   = cnn_pkg::CHAN1,
    parameter int FM_DIM = cnn_pkg::FM1_DIM,
    parameter int WIN    = cnn_pkg::WIN,
    parameter int STRIDE = cnn_pkg::STRIDE
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [CHAN-1:0]                           in_pix,
    output logic                                      win_valid,
    input  logic                                      win_ready,
    output logic                                      win_image [0:CHAN*WIN*WIN-1],
    output logic [$clog2((FM_DIM-WIN)/STRIDE+1)-1:0]  win_row,
    output logic [$clog2((FM_DIM-WIN)/STRIDE+1)-1:0]  win_col,
    output logic                                      frame_done
);
    localparam int OUT_DIM = (FM_DIM - WIN) / STRIDE + 1;
    localparam int CW      = $clog2(FM_DIM);
    localparam int OW      = $clog2(OUT_DIM);
    localparam int DEPTH   = FM_DIM * FM_DIM;
    localparam int AW      = $clog2(DEPTH);

    import cnn_pkg::*;

    fsm_t            state_q;
    logic [CW-1:0]   ld_row_q, ld_col_q;
    logic [OW-1:0]   win_row_q, win_col_q;
    logic            in_ready_q, win_valid_q, frame_done_q;
    logic [CHAN-1:0] mem_q [DEPTH];

    logic            in_fire, win_fire, ld_last, win_last;
    logic [AW-1:0]   wr_addr_d;

    // in_ready_q is only ever high in LOAD and win_valid_q only in EMIT,
    // so each fire term already implies its state.
    assign in_fire   = in_valid && in_ready_q;
    assign win_fire  = win_valid_q && win_ready;
    assign ld_last   = (ld_row_q == CW'(FM_DIM-1)) && (ld_col_q == CW'(FM_DIM-1));
    assign win_last  = (win_row_q == OW'(OUT_DIM-1)) && (win_col_q == OW'(OUT_DIM-1));
    assign wr_addr_d = AW'(int'(ld_row_q) * FM_DIM + int'(ld_col_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (in_fire) begin
            mem_q[wr_addr_d] <= in_pix;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LOAD;
            ld_row_q     <= '0;
            ld_col_q     <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            in_ready_q   <= 1'b1;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_fire) begin
                        if (ld_last) begin
                            state_q     <= EMIT;
                            ld_row_q    <= '0;
                            ld_col_q    <= '0;
                            in_ready_q  <= 1'b0;
                            win_valid_q <= 1'b1;
                        end else if (ld_col_q == CW'(FM_DIM-1)) begin
                            ld_col_q <= '0;
                            ld_row_q <= ld_row_q + CW'(1);
                        end else begin
                            ld_col_q <= ld_col_q + CW'(1);
                        end
                    end
                end
                EMIT: begin
                    if (win_fire) begin
                        if (win_last) begin
                            state_q      <= DONE;
                            win_row_q    <= '0;
                            win_col_q    <= '0;
                            win_valid_q  <= 1'b0;
                            frame_done_q <= 1'b1;
                        end else if (win_col_q == OW'(OUT_DIM-1)) begin
                            win_col_q <= '0;
                            win_row_q <= win_row_q + OW'(1);
                        end else begin
                            win_col_q <= win_col_q + OW'(1);
                        end
                    end
                end
                DONE: begin
                    state_q      <= LOAD;
                    win_row_q    <= '0;
                    win_col_q    <= '0;
                    frame_done_q <= 1'b0;
                    in_ready_q   <= 1'b1;
                end
                default: begin
                    state_q      <= LOAD;
                    in_ready_q   <= 1'b1;
                    win_valid_q  <= 1'b0;
                    frame_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;

    window_slice #(
        .CHAN   (CHAN),
        .FM_DIM (FM_DIM),
        .WIN    (WIN),
        .STRIDE (STRIDE),
        .OW     (OW)
    ) u_window_slice (
        .mem_i   (mem_q),
        .row_i   (win_row_q),
        .col_i   (win_col_q),
        .image_o (win_image)
    );
endmodule

// File: tb/tb_conv2_window_loader.sv
module tb_conv2_window_loader;
    localparam int CHAN = 18;
    localparam int FM   = 12;
    localparam int WIN  = 6;
    localparam int NPIX = CHAN * WIN * WIN;
    localparam int OD   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [CHAN-1:0] in_pix;
    logic            win_valid;
    logic            win_ready;
    logic            win_image [0:NPIX-1];
    logic [1:0]      win_row;
    logic [1:0]      win_col;
    logic            frame_done;

    logic [CHAN-1:0] exp_mem [0:FM*FM-1];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv2_window_loader dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pix     (in_pix),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_image  (win_image),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; win_ready = 1'b0; in_pix = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // pat: 0 = all ones, 1 = one-hot channel (r+c)%18, 2 = random
    task automatic load_frame(input int pat, input bit stall, input int nbeats, input bit chk_lat);
        int acc, guard, early;
        bit tog, was;
        logic [CHAN-1:0] p;
        acc = 0; guard = 0; early = 0; tog = 1'b1;
        while (acc < nbeats && guard < 1000) begin
            in_valid = stall ? tog : 1'b1;
            tog = !tog;
            case (pat)
                0: p = '1;
                1: begin p = '0; p[((acc / FM) + (acc % FM)) % CHAN] = 1'b1; end
                default: p = CHAN'($urandom);
            endcase
            in_pix = p;
            was = in_valid && in_ready;
            @(posedge clk); #1;
            guard++;
            if (was) begin
                exp_mem[acc] = p;
                acc++;
            end
            if (acc < nbeats && win_valid) early++;
        end
        in_valid = 1'b0;
        checks++;
        if (acc != nbeats || early != 0)
            $display("FAIL load_accept: accepted %0d early_win_valid %0d, required %0d and 0", acc, early, nbeats);
        if (chk_lat) begin
            checks++;
            if (win_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL load_latency: win_valid %b in_ready %b one cycle after last beat, required 1 and 0", win_valid, in_ready);
        end
        if (acc != nbeats || early != 0) errors++;
        if (chk_lat && (win_valid !== 1'b1 || in_ready !== 1'b0)) errors++;
    endtask

    task automatic consume_frame(input int hold_idx, input bit junk, input bit addr_chk);
        int wr, wc, mism, bad;
        logic e;
        logic snap [0:NPIX-1];
        for (int w = 0; w < OD*OD; w++) begin
            wr = w / OD; wc = w % OD;
            checks++;
            if (win_valid !== 1'b1 || in_ready !== 1'b0 || frame_done !== 1'b0 ||
                win_row !== 2'(wr) || win_col !== 2'(wc)) begin
                errors++;
                $display("FAIL win_ctrl: w=%0d valid %b ready %b done %b pos (%0d,%0d), required 1 0 0 (%0d,%0d)",
                         w, win_valid, in_ready, frame_done, win_row, win_col, wr, wc);
            end
            mism = 0;
            for (int c = 0; c < CHAN; c++)
                for (int r = 0; r < WIN; r++)
                    for (int k = 0; k < WIN; k++) begin
                        e = exp_mem[(wr*2 + r)*FM + wc*2 + k][c];
                        if (win_image[c*WIN*WIN + r*WIN + k] !== e) mism++;
                    end
            checks++;
            if (mism != 0) begin
                errors++;
                $display("FAIL win_image: window (%0d,%0d) has %0d bad bits, required 0", wr, wc, mism);
            end
            if (addr_chk && wr == 1 && wc == 2) begin
                mism = 0;
                for (int c = 0; c < CHAN; c++)
                    for (int r = 0; r < WIN; r++)
                        for (int k = 0; k < WIN; k++)
                            if (win_image[c*36 + r*6 + k] !== (c == (2 + r + 4 + k) % 18)) mism++;
                checks++;
                if (mism != 0) begin
                    errors++;
                    $display("FAIL addr_pattern: window (1,2) has %0d bits off the (6+r+k)%%18 diagonal, required 0", mism);
                end
            end
            if (w == hold_idx) begin
                win_ready = 1'b0;
                for (int i = 0; i < NPIX; i++) snap[i] = win_image[i];
                bad = 0;
                for (int cyc = 0; cyc < 5; cyc++) begin
                    @(posedge clk); #1;
                    if (win_valid !== 1'b1 || win_row !== 2'(wr) || win_col !== 2'(wc)) bad++;
                    for (int i = 0; i < NPIX; i++)
                        if (win_image[i] !== snap[i]) bad++;
                end
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL backpressure_hold: %0d changes over 5 stalled cycles at (%0d,%0d), required 0", bad, wr, wc);
                end
            end
            win_ready = 1'b1;
            if (junk) begin
                in_valid = 1'b1;
                in_pix = CHAN'($urandom);
            end
            @(posedge clk); #1;
        end
        win_ready = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (frame_done !== 1'b1 || win_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL done_state: done %b valid %b ready %b, required 1 0 0", frame_done, win_valid, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (frame_done !== 1'b0 || in_ready !== 1'b1 || win_valid !== 1'b0) begin
            errors++;
            $display("FAIL back_to_load: done %b ready %b valid %b, required 0 1 0", frame_done, in_ready, win_valid);
        end
    endtask

    task automatic test_reset();
        int ones;
        do_reset();
        checks++;
        if (in_ready !== 1'b1 || win_valid !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready %b valid %b done %b, required 1 0 0", in_ready, win_valid, frame_done);
        end
        checks++;
        if (win_row !== 2'd0 || win_col !== 2'd0) begin
            errors++;
            $display("FAIL reset_pos: (%0d,%0d), required (0,0)", win_row, win_col);
        end
        ones = 0;
        for (int i = 0; i < NPIX; i++) if (win_image[i] !== 1'b0) ones++;
        checks++;
        if (ones != 0) begin
            errors++;
            $display("FAIL reset_image: %0d non-zero bits, required 0", ones);
        end
    endtask

    task automatic test_reset_mid_load();
        int ones;
        load_frame(2, 1'b0, 50, 1'b0);
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || win_valid !== 1'b0) begin
            errors++;
            $display("FAIL midload_ctrl: ready %b valid %b, required 1 0", in_ready, win_valid);
        end
        ones = 0;
        for (int i = 0; i < NPIX; i++) if (win_image[i] !== 1'b0) ones++;
        checks++;
        if (ones != 0) begin
            errors++;
            $display("FAIL midload_cleared: %0d stale bits in buffer, required 0", ones);
        end
        load_frame(0, 1'b0, FM*FM, 1'b1);
        consume_frame(-1, 1'b0, 1'b0);
    endtask

    task automatic test_address_pattern();
        load_frame(1, 1'b0, FM*FM, 1'b1);
        consume_frame(-1, 1'b0, 1'b1);
    endtask

    task automatic test_input_stalls();
        load_frame(1, 1'b1, FM*FM, 1'b1);
        consume_frame(-1, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        load_frame(2, 1'b0, FM*FM, 1'b1);
        consume_frame(1, 1'b0, 1'b0);
    endtask

    task automatic test_ignored_input();
        int mism;
        load_frame(2, 1'b0, FM*FM, 1'b1);
        consume_frame(-1, 1'b1, 1'b0);
        // Back in LOAD at position (0,0): the slice shows buffer entries that
        // junk beats during EMIT would have hit first.
        mism = 0;
        for (int c = 0; c < CHAN; c++)
            for (int r = 0; r < WIN; r++)
                for (int k = 0; k < WIN; k++)
                    if (win_image[c*36 + r*6 + k] !== exp_mem[r*FM + k][c]) mism++;
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL ignored_input: %0d corrupted bits in window (0,0) after EMIT, required 0", mism);
        end
    endtask

    task automatic test_throughput();
        int fd_cnt, fd1, fd2, rdy_bad, overlap, cyc;
        bit exp_rdy;
        fd_cnt = 0; fd1 = -1; fd2 = -1; rdy_bad = 0; overlap = 0;
        do_reset();
        in_valid = 1'b1; win_ready = 1'b1; in_pix = 18'h2AAAA;
        for (int n = 1; n <= 330; n++) begin
            @(posedge clk); #1;
            cyc = n + 1;
            if (frame_done === 1'b1) begin
                fd_cnt++;
                if (fd_cnt == 1) fd1 = cyc;
                else if (fd_cnt == 2) fd2 = cyc;
            end
            exp_rdy = !((cyc >= 145 && cyc <= 161) || (cyc >= 306 && cyc <= 322));
            if (in_ready !== exp_rdy) rdy_bad++;
            if (in_ready === 1'b1 && win_valid === 1'b1) overlap++;
        end
        in_valid = 1'b0; win_ready = 1'b0;
        checks++;
        if (fd_cnt != 2 || fd1 != 161 || fd2 != 322) begin
            errors++;
            $display("FAIL throughput_done: %0d pulses at cycles %0d,%0d, required 2 at 161,322", fd_cnt, fd1, fd2);
        end
        checks++;
        if (rdy_bad != 0) begin
            errors++;
            $display("FAIL throughput_ready: %0d cycles with wrong in_ready, required 0", rdy_bad);
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL ready_valid_overlap: %0d cycles with in_ready and win_valid both high, required 0", overlap);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; win_ready = 1'b0; in_pix = '0;
        test_reset();
        test_reset_mid_load();
        test_address_pattern();
        test_input_stalls();
        test_backpressure();
        test_ignored_input();
        test_throughput();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
